fft_stage_ctrl: RTL and testbench

// - Sequencer for the in-place radix-2 DIT FFT core.
// - Walks log2(N) stages of N/2 butterflies and issues one butterfly per cycle.
// - Drives the dual-port sample RAM read/write addresses and the twiddle ROM index.
// - Delays write-back by the butterfly pipeline latency and reports busy/done to the top level.

---
 rtl/fft_stage_ctrl_if.sv | 29 ++
 rtl/fft_stage_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_ctrl_if.sv
// rtl/fft_stage_ctrl_if.sv - control, RAM and twiddle bus of the FFT stage sequencer
interface fft_stage_ctrl_if #(
    parameter int N_LOG2 = 4
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [N_LOG2-1:0] stage;
    logic              rd_en;
    logic [N_LOG2-1:0] rd_addr_a;
    logic [N_LOG2-1:0] rd_addr_b;
    logic [N_LOG2-2:0] tw_addr;
    logic              wr_en;
    logic [N_LOG2-1:0] wr_addr_a;
    logic [N_LOG2-1:0] wr_addr_b;

    modport master (
        input  start, abort,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, abort,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// rtl/fft_stage_ctrl.sv - radix-2 DIT FFT stage/butterfly sequencer with delayed write-back
module fft_stage_ctrl #(
    parameter int N_LOG2 = 4,
    parameter int BF_LAT = 2
) (
    input logic              clk,
    input logic              rst_n,
    fft_stage_ctrl_if.master bus
);
    localparam int                BW       = N_LOG2 - 1;
    localparam int                CW       = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam int                PW       = 1 + 2 * N_LOG2;
    localparam logic [BW-1:0]     BF_LAST  = '1;
    localparam logic [BW-1:0]     BF_ONE   = BW'(1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(BF_LAT - 1);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [N_LOG2-1:0] ST_LAST  = N_LOG2'(N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] ONE_N    = N_LOG2'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [BW-1:0]     bf, bf_n;
    logic [N_LOG2-1:0] st, st_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              flush;

    logic [N_LOG2-1:0] bf_ext, span, j, k, a_n, b_n, k_sh;
    logic [N_LOG2-2:0] tw_n;

    logic              busy_q, done_q, rd_en_q;
    logic [N_LOG2-1:0] stage_q, rd_a_q, rd_b_q;
    logic [N_LOG2-2:0] tw_q;
    logic [PW-1:0]     pipe [BF_LAT];

    // FSM and butterfly/stage/drain counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bf    <= '0;
            st    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            bf    <= bf_n;
            st    <= st_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state logic; abort only cancels work that is actually in flight
    always_comb begin
        state_n = state;
        bf_n    = bf;
        st_n    = st;
        cnt_n   = cnt;
        flush   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_n = RUN;
                    bf_n    = '0;
                    st_n    = '0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    bf_n    = '0;
                    st_n    = '0;
                    flush   = 1'b1;
                end else if (bf == BF_LAST) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    bf_n = bf + BF_ONE;
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    bf_n    = '0;
                    st_n    = '0;
                    flush   = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    if (st == ST_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        st_n    = st + ONE_N;
                        bf_n    = '0;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
                bf_n    = '0;
                st_n    = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Butterfly addressing for the upcoming cycle: group j, offset k within the group
    always_comb begin
        bf_ext = {1'b0, bf_n};
        span   = ONE_N << st_n;
        j      = bf_ext >> st_n;
        k      = bf_ext & (span - ONE_N);
        a_n    = (j << (st_n + ONE_N)) + k;
        b_n    = a_n + span;
        k_sh   = k << (ST_LAST - st_n);
        tw_n   = k_sh[N_LOG2-2:0];
    end

    // Registered outputs, loaded from the next-state view so they align with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            stage_q <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            busy_q  <= (state_n == RUN) || (state_n == DRAIN);
            done_q  <= (state_n == DONE);
            rd_en_q <= (state_n == RUN);
            stage_q <= st_n;
            rd_a_q  <= (state_n == RUN) ? a_n  : '0;
            rd_b_q  <= (state_n == RUN) ? b_n  : '0;
            tw_q    <= (state_n == RUN) ? tw_n : '0;
        end
    end

    // Write-back delay line matching the RAM read plus butterfly latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < BF_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {rd_en_q, rd_a_q, rd_b_q};
            for (int i = 1; i < BF_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = stage_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_a_q;
    assign bus.rd_addr_b = rd_b_q;
    assign bus.tw_addr   = tw_q;
    assign bus.wr_en     = pipe[BF_LAT-1][PW-1];
    assign bus.wr_addr_a = pipe[BF_LAT-1][2*N_LOG2-1:N_LOG2];
    assign bus.wr_addr_b = pipe[BF_LAT-1][N_LOG2-1:0];
endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb/tb_fft_stage_ctrl.sv - scoreboard bench for fft_stage_ctrl
module tb_fft_stage_ctrl;
    localparam int N_LOG2 = 4;
    localparam int BF_LAT = 2;
    localparam int HALF   = 8;
    localparam int PERIOD = HALF + BF_LAT;

    typedef struct {
        int off;
        int st;
        int a;
        int b;
        int tw;
    } exp_t;

    logic clk;
    logic rst_n;
    fft_stage_ctrl_if #(.N_LOG2(N_LOG2)) bus ();

    fft_stage_ctrl #(.N_LOG2(N_LOG2), .BF_LAT(BF_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t rq[$];
    exp_t wq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   t0       = 0;
    int   run_id   = 0;
    int   seen_id  = 0;
    int   busy_cnt, busy_first, busy_last, done_cnt, done_off, rd_cnt, wr_cnt;
    int   obs_a [64];
    int   obs_b [64];
    int   obs_tw [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected butterfly schedule: for each stage, walk groups then offsets within a group
    task automatic push_exp(input int lim);
        exp_t e;
        for (int s = 0; s < N_LOG2; s++) begin
            int span = 1 << s;
            for (int g = 0; g < HALF / span; g++) begin
                for (int kk = 0; kk < span; kk++) begin
                    e.off = 1 + s * PERIOD + g * span + kk;
                    e.st  = s;
                    e.a   = g * 2 * span + kk;
                    e.b   = e.a + span;
                    e.tw  = kk * (HALF / span);
                    if (e.off <= lim) rq.push_back(e);
                    e.off = e.off + BF_LAT;
                    if (e.off <= lim) wq.push_back(e);
                end
            end
        end
    endtask

    // Monitor: pops the scoreboard on every read/write strobe and gathers run statistics
    always @(negedge clk) begin
        int   off;
        exp_t e;
        if (run_id != seen_id) begin
            seen_id    = run_id;
            busy_cnt   = 0;
            busy_first = -1;
            busy_last  = -1;
            done_cnt   = 0;
            done_off   = -1;
            rd_cnt     = 0;
            wr_cnt     = 0;
        end
        off = cyc - t0;
        if (bus.busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = off;
            busy_last = off;
        end
        if (bus.done) begin
            done_cnt++;
            done_off = off;
        end
        if (bus.rd_en) begin
            if (rq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = rq.pop_front();
                chk("rd_off",   off,                e.off);
                chk("rd_stage", int'(bus.stage),    e.st);
                chk("rd_a",     int'(bus.rd_addr_a), e.a);
                chk("rd_b",     int'(bus.rd_addr_b), e.b);
                chk("rd_tw",    int'(bus.tw_addr),   e.tw);
            end
            if (rd_cnt < 64) begin
                obs_a[rd_cnt]  = int'(bus.rd_addr_a);
                obs_b[rd_cnt]  = int'(bus.rd_addr_b);
                obs_tw[rd_cnt] = int'(bus.tw_addr);
            end
            rd_cnt++;
        end
        if (bus.wr_en) begin
            if (wq.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e = wq.pop_front();
                chk("wr_off", off,                  e.off);
                chk("wr_a",   int'(bus.wr_addr_a),  e.a);
                chk("wr_b",   int'(bus.wr_addr_b),  e.b);
            end
            wr_cnt++;
        end
    end

    function automatic int out_bits();
        return int'({bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
                     bus.tw_addr, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b});
    endfunction

    // One FFT attempt: optional abort/reset offset, start held until hold_until
    task automatic do_run(input int abort_at, input int rst_at, input int hold_until);
        int  lim;
        bit  stop;
        @(posedge clk);
        #1;
        run_id++;
        t0        = cyc;
        bus.start = 1'b1;
        lim = 99;
        if (abort_at >= 0 && abort_at < 41) lim = abort_at;
        if (rst_at >= 0) lim = rst_at - 1;
        push_exp(lim);
        stop = 1'b0;
        for (int off = 1; off <= 44 && !stop; off++) begin
            @(posedge clk);
            #1;
            bus.start = (off < hold_until);
            bus.abort = (off == abort_at);
            if (abort_at >= 0 && abort_at < 41 && off == abort_at + 2) stop = 1'b1;
            if (off == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_outputs_zero", out_bits(), 0);
                bus.start = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_busy_held", int'(bus.busy), 0);
                bus.start = 1'b0;
                rst_n     = 1'b1;
                stop      = 1'b1;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic check_full(input string tag);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_busy_cnt"},   busy_cnt,   40);
        chk({tag, "_busy_first"}, busy_first, 1);
        chk({tag, "_busy_last"},  busy_last,  40);
        chk({tag, "_done_cnt"},   done_cnt,   1);
        chk({tag, "_done_off"},   done_off,   41);
        chk({tag, "_rd_cnt"},     rd_cnt,     32);
        chk({tag, "_wr_cnt"},     wr_cnt,     32);
        chk({tag, "_rq_left"},    rq.size(),  0);
        chk({tag, "_wq_left"},    wq.size(),  0);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", out_bits(), 0);
        rst_n = 1'b1;

        do_run(-1, -1, 1);
        check_full("basic");
        chk("s0bf1_a", obs_a[1], 2);   chk("s0bf1_b", obs_b[1], 3);   chk("s0bf1_tw", obs_tw[1], 0);
        chk("s1bf1_a", obs_a[9], 1);   chk("s1bf1_b", obs_b[9], 3);   chk("s1bf1_tw", obs_tw[9], 4);
        chk("s2bf5_a", obs_a[21], 9);  chk("s2bf5_b", obs_b[21], 13); chk("s2bf5_tw", obs_tw[21], 2);
        chk("s3bf5_a", obs_a[29], 5);  chk("s3bf5_b", obs_b[29], 13); chk("s3bf5_tw", obs_tw[29], 5);

        do_run(-1, -1, 30);
        check_full("start_held");

        @(posedge clk);
        #1;
        run_id++;
        t0        = cyc;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_abort_idle_busy", busy_cnt, 0);
        chk("start_abort_idle_rd",   rd_cnt,   0);

        do_run(25, -1, 1);
        chk("abort_busy_last", busy_last, 25);
        chk("abort_done_cnt",  done_cnt,  0);
        chk("abort_rd_cnt",    rd_cnt,    21);
        chk("abort_wr_cnt",    wr_cnt,    19);
        chk("abort_rq_left",   rq.size(), 0);
        chk("abort_wq_left",   wq.size(), 0);
        do_run(-1, -1, 1);
        check_full("after_abort");

        do_run(41, -1, 1);
        check_full("abort_in_done");

        do_run(-1, 19, 1);
        chk("rst_done_cnt", done_cnt,  0);
        chk("rst_rd_cnt",   rd_cnt,    16);
        chk("rst_wr_cnt",   wr_cnt,    14);
        chk("rst_rq_left",  rq.size(), 0);
        chk("rst_wq_left",  wq.size(), 0);
        do_run(-1, -1, 1);
        check_full("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
